load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-stage load/store unit of the RISC-V pipeline. It sits directly upstream of `memoryFile`. It accepts one load or store per request from the MEM stage and drives `memoryFile`'s valid/write-enable/address/data handshake with doubleword-aligned accesses. It performs read-modify-write for sub-doubleword stores, extracts and sign/zero-extends load results, and stalls the pipeline while `memoryFile` reports `v_mem_stall`.

## Interface
- `XLEN`, 64: data and address width; byte lanes are little-endian.
- `CLK` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `MEM_V` in 1: MEM-stage instruction valid.
- `MEM_LD` / `MEM_ST` in 1 each: instruction is a load / a store; both high is treated as a store.
- `MEM_FUNCT3` in 3: RV64 size/sign code.
- `MEM_ADDR` in XLEN: effective byte address.
- `MEM_STORE_DATA` in XLEN: store source, right-justified.
- `LSU_STALL` out 1: hold the pipeline.
- `LSU_DONE` out 1: one-cycle completion pulse.
- `LSU_LOAD_DATA` out XLEN: extended load result; valid while `LSU_DONE` is high.
- `LSU_MISALIGNED` out 1: pulses with `LSU_DONE` when the request was dropped for misalignment.
- `mem_v` out 1: to `memoryFile` `MEM_V`.
- `mem_we` out 1: to `memoryFile` `we`.
- `mem_address` out XLEN: to `address`; bits [2:0] are always 0.
- `mem_data` out XLEN: to `mem_data`.
- `mem_stall` in 1: from `v_mem_stall`.
- `mem_rdata` in XLEN: from `data_out`.

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - Accept when `MEM_V && (MEM_LD || MEM_ST)`. Latch funct3, address, store data and the load/store flag.
  - Load, or store with funct3 000/001/010 (SB/SH/SW): go to READ.
  - SD (011): go to WRITE.
  - Misaligned request or illegal funct3: go to DONE with no memory access. Illegal is funct3 111 on a load, or 1xx on a store.
- Alignment rules: H requires addr[0]=0; W requires addr[1:0]=0; D requires addr[2:0]=0.
- READ:
  - `mem_v`=1, `mem_we`=0, `mem_address`={addr[63:3],3'b0}.
  - Hold while `mem_stall`=1.
  - On `mem_stall`=0, capture `mem_rdata`.
  - For a load: select lane at offset addr[2:0]; sign-extend for 000/001/010, zero-extend for 100/101/110, pass through for 011; go to DONE.
  - For a store: merge store bytes into the captured doubleword at addr[2:0]; go to WRITE.
- WRITE: `mem_v`=1, `mem_we`=1, `mem_data`=merged doubleword, or `MEM_STORE_DATA` for SD. Hold while `mem_stall`=1; go to DONE when `mem_stall`=0.
- DONE: `LSU_DONE`=1; always returns to IDLE; no request is accepted in DONE.
- `mem_v`, `mem_we` and `mem_address` decode from registered state only; they are never combinational from MEM-stage inputs.
- Illegal funct3 completes with `LSU_LOAD_DATA`=0, `LSU_MISALIGNED`=0 and no write.

## Timing
- `LSU_STALL` = (state is READ or WRITE) or (state is IDLE and a request is accepted). It is combinational, so it is high in the accept cycle.
- `LSU_STALL`=0 in DONE; the pipeline advances at the DONE edge.
- Latency from the accept cycle to the `LSU_DONE` cycle, with a zero-wait memory:
  - Load: 2 cycles.
  - SD: 2 cycles.
  - SB/SH/SW: 3 cycles.
  - Dropped request: 1 cycle.
  - Each `mem_stall` cycle adds 1.
- A memory write commits at the edge where `mem_we`=1 and `mem_stall`=0.
- `MEM_V` and MEM inputs changing after accept have no effect.
- Reset values: state IDLE; all outputs 0, including `LSU_LOAD_DATA` and `mem_address`.
- Reset mid-operation: the FSM returns to IDLE at the reset edge and the access is abandoned. A WRITE completing at that same edge still commits.
- `LSU_LOAD_DATA` holds its value after DONE until the next load completes.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined: misaligned requests are dropped and `LSU_MISALIGNED` pulses as above.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - No misalignment check; `LSU_MISALIGNED` is tied 0.
  - The address is force-aligned to the access size (low bits cleared) and the access proceeds normally.

## Test plan
- Preload 0x8877665544332211 at 0x10; LB at 0x17, then LBU at 0x17 -> `LSU_LOAD_DATA`=0xFFFFFFFFFFFFFF88, then 0x88, each 2 cycles after accept.
- SH 0xBEEF at 0x12 over 0x8877665544332211 -> one READ, then a WRITE of 0x88776655BEEF2211 to address 0x10; DONE 3 cycles after accept.
- SD 67 to address 0 with 2 `mem_stall` cycles -> no READ; WRITE held 3 cycles; `LSU_STALL` high for 4 cycles; DONE at cycle 4.
- LW at 0x0A:
  - With `LSU_MISALIGN_TRAP_EN`: `mem_v` never rises; `LSU_MISALIGNED`=1 and `LSU_DONE`=1 in the next cycle.
  - Without it: a read of 0x08 returns the word at 0x08.
- `reset` asserted during the READ of an SB -> IDLE after the edge, all outputs 0, memory contents unchanged.
- Back-to-back LD 0x00 then LD 0x08 -> the second request is accepted in the IDLE cycle after DONE; each returns its preloaded doubleword.

Source files
------------

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: doubleword-aligned accesses to memoryFile with RMW for sub-doubleword stores.
// Optional LSU_MISALIGN_TRAP_EN: drop misaligned requests and flag them instead of force-aligning the address.
module load_store_unit #(
    parameter int XLEN = 64
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic            MEM_V,
    input  logic            MEM_LD,
    input  logic            MEM_ST,
    input  logic [2:0]      MEM_FUNCT3,
    input  logic [XLEN-1:0] MEM_ADDR,
    input  logic [XLEN-1:0] MEM_STORE_DATA,
    output logic            LSU_STALL,
    output logic            LSU_DONE,
    output logic [XLEN-1:0] LSU_LOAD_DATA,
    output logic            LSU_MISALIGNED,
    output logic            mem_v,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_address,
    output logic [XLEN-1:0] mem_data,
    input  logic            mem_stall,
    input  logic [XLEN-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t          state;
    logic [2:0]      funct3;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] load_data;
    logic            is_store;

    logic            accept;
    logic            req_illegal;
    logic            req_drop;
    logic [2:0]      size_mask;
    logic [XLEN-1:0] req_addr;

    assign accept      = MEM_V && (MEM_LD || MEM_ST);
    assign req_illegal = MEM_ST ? MEM_FUNCT3[2] : (MEM_FUNCT3 == 3'b111);

    always_comb begin
        case (MEM_FUNCT3[1:0])
            2'b00:   size_mask = 3'b000;
            2'b01:   size_mask = 3'b001;
            2'b10:   size_mask = 3'b011;
            default: size_mask = 3'b111;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic req_misaligned;
    logic misaligned;

    assign req_misaligned = (MEM_ADDR[2:0] & size_mask) != 3'b000;
    assign req_drop       = req_illegal || req_misaligned;
    assign req_addr       = MEM_ADDR;
    assign LSU_MISALIGNED = (state == DONE) && misaligned;

    // An illegal funct3 wins over misalignment, so only legal-but-misaligned requests raise the flag.
    always_ff @(posedge CLK) begin
        if (reset)
            misaligned <= 1'b0;
        else if (state == IDLE && accept)
            misaligned <= req_misaligned && !req_illegal;
    end
`else
    assign req_drop       = req_illegal;
    assign req_addr       = {MEM_ADDR[XLEN-1:3], MEM_ADDR[2:0] & ~size_mask};
    assign LSU_MISALIGNED = 1'b0;
`endif

    logic [5:0]      lane_shift;
    logic [XLEN-1:0] lane;
    logic [XLEN-1:0] load_ext;
    logic [7:0]      base_mask;
    logic [7:0]      byte_mask;
    logic [XLEN-1:0] store_shift;
    logic [XLEN-1:0] merged;

    assign lane_shift = {addr[2:0], 3'b000};

    always_comb begin
        lane = mem_rdata >> lane_shift;
        case (funct3)
            3'b000:  load_ext = {{(XLEN-8){lane[7]}}, lane[7:0]};
            3'b001:  load_ext = {{(XLEN-16){lane[15]}}, lane[15:0]};
            3'b010:  load_ext = {{(XLEN-32){lane[31]}}, lane[31:0]};
            3'b100:  load_ext = {{(XLEN-8){1'b0}}, lane[7:0]};
            3'b101:  load_ext = {{(XLEN-16){1'b0}}, lane[15:0]};
            3'b110:  load_ext = {{(XLEN-32){1'b0}}, lane[31:0]};
            default: load_ext = lane;
        endcase
    end

    // Store bytes are shifted into their lanes and overlaid on the doubleword just read.
    always_comb begin
        case (funct3[1:0])
            2'b00:   base_mask = 8'h01;
            2'b01:   base_mask = 8'h03;
            2'b10:   base_mask = 8'h0F;
            default: base_mask = 8'hFF;
        endcase
        byte_mask   = base_mask << addr[2:0];
        store_shift = wdata << lane_shift;
        merged      = mem_rdata;
        for (int i = 0; i < 8; i++) begin
            if (byte_mask[i])
                merged[8*i +: 8] = store_shift[8*i +: 8];
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state     <= IDLE;
            funct3    <= 3'b000;
            addr      <= '0;
            wdata     <= '0;
            load_data <= '0;
            is_store  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        funct3   <= MEM_FUNCT3;
                        addr     <= req_addr;
                        wdata    <= MEM_STORE_DATA;
                        is_store <= MEM_ST;
                        if (req_drop) begin
                            load_data <= '0;
                            state     <= DONE;
                        end else if (MEM_ST && MEM_FUNCT3[1:0] == 2'b11) begin
                            state <= WRITE;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: begin
                    if (!mem_stall) begin
                        if (is_store) begin
                            wdata <= merged;
                            state <= WRITE;
                        end else begin
                            load_data <= load_ext;
                            state     <= DONE;
                        end
                    end
                end
                WRITE: begin
                    if (!mem_stall)
                        state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_v         = (state == READ) || (state == WRITE);
    assign mem_we        = (state == WRITE);
    assign mem_address   = mem_v ? {addr[XLEN-1:3], 3'b000} : '0;
    assign mem_data      = mem_we ? wdata : '0;
    assign LSU_DONE      = (state == DONE);
    assign LSU_LOAD_DATA = load_data;
    assign LSU_STALL     = mem_v || ((state == IDLE) && accept);
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized requests against a byte-level memory model.
module tb_load_store_unit;
    logic        CLK;
    logic        reset;
    logic        MEM_V;
    logic        MEM_LD;
    logic        MEM_ST;
    logic [2:0]  MEM_FUNCT3;
    logic [63:0] MEM_ADDR;
    logic [63:0] MEM_STORE_DATA;
    logic        LSU_STALL;
    logic        LSU_DONE;
    logic [63:0] LSU_LOAD_DATA;
    logic        LSU_MISALIGNED;
    logic        mem_v;
    logic        mem_we;
    logic [63:0] mem_address;
    logic [63:0] mem_data;
    logic        mem_stall;
    logic [63:0] mem_rdata;

    load_store_unit #(.XLEN(64)) dut (
        .CLK(CLK), .reset(reset),
        .MEM_V(MEM_V), .MEM_LD(MEM_LD), .MEM_ST(MEM_ST), .MEM_FUNCT3(MEM_FUNCT3),
        .MEM_ADDR(MEM_ADDR), .MEM_STORE_DATA(MEM_STORE_DATA),
        .LSU_STALL(LSU_STALL), .LSU_DONE(LSU_DONE), .LSU_LOAD_DATA(LSU_LOAD_DATA),
        .LSU_MISALIGNED(LSU_MISALIGNED),
        .mem_v(mem_v), .mem_we(mem_we), .mem_address(mem_address), .mem_data(mem_data),
        .mem_stall(mem_stall), .mem_rdata(mem_rdata)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Stand-in for memoryFile: 256 bytes as 32 doublewords, with a backdoor port for preloading.
    logic [63:0] mem [0:31];
    logic        bd_we;
    logic [4:0]  bd_idx;
    logic [63:0] bd_val;
    int          rd_cnt;
    int          wr_cnt;
    logic [63:0] last_wr_addr;

    assign mem_rdata = mem[mem_address[7:3]];

    always @(posedge CLK) begin
        if (bd_we) begin
            mem[bd_idx] <= bd_val;
        end else if (mem_v && !mem_stall) begin
            if (mem_we) begin
                mem[mem_address[7:3]] <= mem_data;
                wr_cnt       <= wr_cnt + 1;
                last_wr_addr <= mem_address;
            end else begin
                rd_cnt <= rd_cnt + 1;
            end
        end
    end

    // Reference model: a flat little-endian byte array.
    logic [7:0]  ref_mem [0:255];
    int          checks;
    int          errors;
    logic [63:0] last_ld;
    bit          ld_known;
    logic [63:0] last_obs;

    function automatic logic [63:0] refLoad(input logic [2:0] f3, input logic [63:0] a);
        int sz = 1 << f3[1:0];
        logic [63:0] v = '0;
        for (int i = 0; i < sz; i++)
            v = v | (64'(ref_mem[int'(a[7:0]) + i]) << (8 * i));
        if (!f3[2] && sz < 8 && v[8*sz-1])
            v = v | (~64'h0 << (8 * sz));
        return v;
    endfunction

    function automatic void refStore(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] d);
        int sz = 1 << f3[1:0];
        for (int i = 0; i < sz; i++)
            ref_mem[int'(a[7:0]) + i] = d[8*i +: 8];
    endfunction

    function automatic logic [63:0] refDword(input int idx);
        logic [63:0] v = '0;
        for (int i = 0; i < 8; i++)
            v = v | (64'(ref_mem[idx*8 + i]) << (8 * i));
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
        end
    endtask

    // Drives one request, scrambles the MEM inputs afterwards, and inserts memory stalls while mem_v is high.
    task automatic applyStimulus(input logic ld, input logic st, input logic [2:0] f3,
                                 input logic [63:0] addr, input logic [63:0] data,
                                 input int forced_stalls, input bit rand_stalls,
                                 output int lat, output int stall_hi, output int stalls_driven,
                                 output logic [63:0] ldata, output logic mis,
                                 output logic done_stall, output bit timed_out);
        int left = forced_stalls;
        @(negedge CLK);
        MEM_V = 1'b1; MEM_LD = ld; MEM_ST = st; MEM_FUNCT3 = f3;
        MEM_ADDR = addr; MEM_STORE_DATA = data; mem_stall = 1'b0;
        #1;
        stall_hi = LSU_STALL ? 1 : 0;
        lat = 0; stalls_driven = 0; ldata = '0; mis = 1'b0; done_stall = 1'b0; timed_out = 1'b1;
        @(posedge CLK);
        for (int c = 1; c <= 64; c++) begin
            @(negedge CLK);
            MEM_V = 1'($urandom_range(0, 1));
            MEM_LD = 1'($urandom_range(0, 1));
            MEM_ST = 1'($urandom_range(0, 1));
            MEM_FUNCT3 = 3'($urandom);
            MEM_ADDR = {$urandom, $urandom};
            MEM_STORE_DATA = {$urandom, $urandom};
            if (mem_v && left > 0) begin
                mem_stall = 1'b1; left--; stalls_driven++;
            end else if (mem_v && rand_stalls && $urandom_range(0, 2) == 0) begin
                mem_stall = 1'b1; stalls_driven++;
            end else begin
                mem_stall = 1'b0;
            end
            #1;
            if (LSU_DONE) begin
                lat = c; ldata = LSU_LOAD_DATA; mis = LSU_MISALIGNED;
                done_stall = LSU_STALL; timed_out = 1'b0;
                break;
            end
            if (LSU_STALL) stall_hi++;
            @(posedge CLK);
        end
    endtask

    task automatic runOp(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] data,
                         input int forced_stalls, input bit rand_stalls);
        int rd0 = rd_cnt;
        int wr0 = wr_cnt;
        int sz, base, exp_rd, exp_wr, lat, stall_hi, sd;
        bit illegal, mis_exp, drop, to;
        logic [63:0] eaddr, ldata, exp_ld;
        logic mis, dstall;
        sz = 1 << f3[1:0];
        illegal = st ? f3[2] : (f3 == 3'b111);
`ifdef LSU_MISALIGN_TRAP_EN
        mis_exp = !illegal && ((addr & 64'(sz - 1)) != 0);
        eaddr = addr;
`else
        mis_exp = 1'b0;
        eaddr = addr & ~64'(sz - 1);
`endif
        drop = illegal || mis_exp;
        if (drop) begin
            base = 1; exp_rd = 0; exp_wr = 0;
        end else if (st && f3[1:0] == 2'b11) begin
            base = 2; exp_rd = 0; exp_wr = 1;
        end else if (st) begin
            base = 3; exp_rd = 1; exp_wr = 1;
        end else begin
            base = 2; exp_rd = 1; exp_wr = 0;
        end
        applyStimulus(ld, st, f3, addr, data, forced_stalls, rand_stalls,
                      lat, stall_hi, sd, ldata, mis, dstall, to);
        last_obs = ldata;
        checkOutput("timeout", 64'(to), 64'd0);
        checkOutput("latency", 64'(lat), 64'(base + sd));
        checkOutput("stall_cycles", 64'(stall_hi), 64'(base + sd));
        checkOutput("stall_in_done", 64'(dstall), 64'd0);
        checkOutput("misaligned", 64'(mis), 64'(mis_exp));
        checkOutput("reads", 64'(rd_cnt - rd0), 64'(exp_rd));
        checkOutput("writes", 64'(wr_cnt - wr0), 64'(exp_wr));
        if (drop) begin
            if (illegal) begin
                checkOutput("illegal_ldata", ldata, 64'd0);
                last_ld = '0; ld_known = 1'b1;
            end else begin
                ld_known = 1'b0;
            end
        end else if (!st) begin
            exp_ld = refLoad(f3, eaddr);
            checkOutput("load_data", ldata, exp_ld);
            last_ld = exp_ld; ld_known = 1'b1;
        end else begin
            refStore(f3, eaddr, data);
            checkOutput("write_addr", last_wr_addr, {eaddr[63:3], 3'b000});
            if (ld_known) checkOutput("ldata_hold", ldata, last_ld);
        end
    endtask

    initial begin
        logic [63:0] v;
        int wr0;
        checks = 0; errors = 0; ld_known = 1'b0; last_ld = '0;
        reset = 1'b1; MEM_V = 1'b0; MEM_LD = 1'b0; MEM_ST = 1'b0; MEM_FUNCT3 = 3'b000;
        MEM_ADDR = '0; MEM_STORE_DATA = '0; mem_stall = 1'b0;
        bd_we = 1'b0; bd_idx = '0; bd_val = '0;

        for (int idx = 0; idx < 32; idx++) begin
            v = (idx == 2) ? 64'h8877665544332211 : {$urandom, $urandom};
            @(negedge CLK);
            bd_we = 1'b1; bd_idx = 5'(idx); bd_val = v;
            for (int b = 0; b < 8; b++) ref_mem[idx*8 + b] = v[8*b +: 8];
        end
        @(negedge CLK);
        bd_we = 1'b0;
        @(negedge CLK);
        #1;
        checkOutput("rst_stall", 64'(LSU_STALL), 64'd0);
        checkOutput("rst_done", 64'(LSU_DONE), 64'd0);
        checkOutput("rst_ldata", LSU_LOAD_DATA, 64'd0);
        checkOutput("rst_mis", 64'(LSU_MISALIGNED), 64'd0);
        checkOutput("rst_memv_we", {62'd0, mem_v, mem_we}, 64'd0);
        checkOutput("rst_addr", mem_address, 64'd0);
        checkOutput("rst_mdata", mem_data, 64'd0);
        reset = 1'b0;
        last_ld = '0; ld_known = 1'b1;

        $display("[TB] directed: sign/zero-extended byte loads");
        runOp(1, 0, 3'b000, 64'h17, 64'd0, 0, 0);
        checkOutput("lb_0x17", last_obs, 64'hFFFFFFFFFFFFFF88);
        runOp(1, 0, 3'b100, 64'h17, 64'd0, 0, 0);
        checkOutput("lbu_0x17", last_obs, 64'h0000000000000088);

        $display("[TB] directed: halfword read-modify-write");
        runOp(0, 1, 3'b001, 64'h12, 64'h000000000000BEEF, 0, 0);
        checkOutput("sh_merge", mem[2], 64'h88776655BEEF2211);

        $display("[TB] directed: SD with two stall cycles");
        runOp(0, 1, 3'b011, 64'h0, 64'd67, 2, 0);
        checkOutput("sd_mem", mem[0], 64'd67);

        $display("[TB] directed: LW at 0x0A");
        runOp(1, 0, 3'b010, 64'h0A, 64'd0, 0, 0);

        $display("[TB] directed: reset during READ of an SB");
        @(negedge CLK);
        MEM_V = 1'b1; MEM_LD = 1'b0; MEM_ST = 1'b1; MEM_FUNCT3 = 3'b000;
        MEM_ADDR = 64'h21; MEM_STORE_DATA = 64'h5A; mem_stall = 1'b0;
        wr0 = wr_cnt;
        @(posedge CLK);
        @(negedge CLK);
        MEM_V = 1'b0; mem_stall = 1'b1;
        #1;
        checkOutput("rst_mid_in_read", 64'(mem_v), 64'd1);
        reset = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        #1;
        checkOutput("rst_mid_memv_we", {62'd0, mem_v, mem_we}, 64'd0);
        checkOutput("rst_mid_done_stall", {62'd0, LSU_DONE, LSU_STALL}, 64'd0);
        checkOutput("rst_mid_addr", mem_address, 64'd0);
        checkOutput("rst_mid_ldata", LSU_LOAD_DATA, 64'd0);
        reset = 1'b0; mem_stall = 1'b0;
        @(negedge CLK);
        #1;
        checkOutput("rst_mid_idle", {62'd0, LSU_DONE, mem_v}, 64'd0);
        checkOutput("rst_mid_no_write", 64'(wr_cnt - wr0), 64'd0);
        checkOutput("rst_mid_mem", mem[4], refDword(4));
        last_ld = '0; ld_known = 1'b1;

        $display("[TB] directed: back-to-back LD");
        runOp(1, 0, 3'b011, 64'h00, 64'd0, 0, 0);
        runOp(1, 0, 3'b011, 64'h08, 64'd0, 0, 0);

        $display("[TB] randomized requests");
        for (int n = 0; n < 120; n++) begin
            int kind = $urandom_range(0, 3);
            runOp(kind < 2 || kind == 3, kind >= 2, 3'($urandom_range(0, 7)),
                  64'($urandom_range(0, 255)), {$urandom, $urandom}, 0, 1'($urandom_range(0, 1)));
        end

        @(negedge CLK);
        MEM_V = 1'b0;
        @(negedge CLK);
        for (int idx = 0; idx < 32; idx++)
            checkOutput($sformatf("final_mem[%0d]", idx), mem[idx], refDword(idx));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
